// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register-file write port between the MW-stage
//                writeback and a long-latency unit. Long-latency results are
//                buffered in a small FIFO and drained into idle writeback
//                slots. A 32-bit pending scoreboard drives the decode stall
//                for RAW/WAW hazards on outstanding long-latency destinations.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,          // async, active-low
   // pipeline MW-stage writeback
   input  logic                     reg_wrMW,
   input  logic [4:0]               waddr_MW,
   input  logic [XLEN-1:0]          wdata_MW,
   // long-latency unit
   input  logic                     lu_issue,
   input  logic [4:0]               lu_issue_rd,
   input  logic                     lu_valid,
   input  logic [4:0]               lu_waddr,
   input  logic [XLEN-1:0]          lu_wdata,
   output logic                     lu_ready,
   // decode hazard inputs
   input  logic [4:0]               raddr1,
   input  logic [4:0]               raddr2,
   input  logic [4:0]               id_rd,
   input  logic                     id_wr,
   // register file write port
   output logic                     rf_we,
   output logic [4:0]               rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
   // status
   output logic                     stall_D,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [31:0]              pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   // FIFO storage and control
   logic [4:0]      addr_mem_q [DEPTH];
   logic [XLEN-1:0] data_mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q,  count_d;
   logic [31:0]     pending_q, pending_d;

   logic            fifo_empty;
   logic            lu_accept;
   logic            push;
   logic            pop;
   logic [4:0]      head_addr;
   logic [XLEN-1:0] head_data;
   logic            sel_pipe;

   assign fifo_empty = (count_q == '0);
   assign head_addr  = addr_mem_q[rd_ptr_q];
   assign head_data  = data_mem_q[rd_ptr_q];

   // Ready comes only from the registered count so the producer never sees
   // a combinational path through the pop decision.
   assign lu_ready   = (count_q < FULL_COUNT);
   assign lu_accept  = lu_valid & lu_ready;
   // Results for x0 complete the handshake but are dropped.
   assign push       = lu_accept & (lu_waddr != 5'd0);

   // The pipeline owns the port whenever it writes; the FIFO only drains
   // into otherwise idle slots.
   assign sel_pipe   = reg_wrMW;
   assign pop        = ~sel_pipe & ~fifo_empty;

   // Write-port mux: pipeline first, then FIFO head; never write x0.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = '0;
      if (sel_pipe) begin
         rf_waddr = waddr_MW;
         rf_wdata = wdata_MW;
         rf_we    = (waddr_MW != 5'd0);
      end else if (!fifo_empty) begin
         rf_waddr = head_addr;
         rf_wdata = head_data;
         rf_we    = (head_addr != 5'd0);
      end
   end

   // Decode stall on any source, destination or newly issued destination
   // that still waits for a long-latency result.
   assign stall_D = pending_q[raddr1]
                  | pending_q[raddr2]
                  | (id_wr    & pending_q[id_rd])
                  | (lu_issue & pending_q[lu_issue_rd]);

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Scoreboard next-state: clear on drain, then set so a same-cycle set wins.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_addr] = 1'b0;
      end
      if (lu_issue && (lu_issue_rd != 5'd0) && !stall_D) begin
         pending_d[lu_issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Control state registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         pending_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         pending_q <= pending_d;
      end
   end

   // FIFO payload storage; contents are meaningless while count is zero,
   // so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= lu_waddr;
         data_mem_q[wr_ptr_q] <= lu_wdata;
      end
   end

   assign fifo_count = count_q;
   assign pending    = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed self-checking bench for regfile_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        reg_wrMW;
   logic [4:0]  waddr_MW;
   logic [31:0] wdata_MW;
   logic        lu_issue;
   logic [4:0]  lu_issue_rd;
   logic        lu_valid;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic [4:0]  id_rd;
   logic        id_wr;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_D;
   logic [1:0]  fifo_count;
   logic [31:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
      .clk(clk), .rst(rst),
      .reg_wrMW(reg_wrMW), .waddr_MW(waddr_MW), .wdata_MW(wdata_MW),
      .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
      .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
      .lu_ready(lu_ready),
      .raddr1(raddr1), .raddr2(raddr2), .id_rd(id_rd), .id_wr(id_wr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall_D(stall_D), .fifo_count(fifo_count), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs are checked #2 later, well away from either edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reg_wrMW = 0; waddr_MW = 0; wdata_MW = 0;
      lu_issue = 0; lu_issue_rd = 0;
      lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
      raddr1 = 0; raddr2 = 0; id_rd = 0; id_wr = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      tick(); #2;
      n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 00000000", pending); end
      n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", lu_ready); end
      n_checks++; if (rf_we !== 1'b0 || stall_D !== 1'b0) begin n_fail++; $display("FAIL reset_we_stall: got we=%b stall=%b expected 0 0", rf_we, stall_D); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic_drain();
      lu_issue = 1; lu_issue_rd = 5'd5;
      #2;
      n_checks++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL drain_issue_stall: got %b expected 0", stall_D); end
      tick();
      lu_issue = 0; lu_valid = 1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
      #2;
      n_checks++; if (pending !== 32'h0000_0020) begin n_fail++; $display("FAIL drain_pending_set: got %h expected 00000020", pending); end
      n_checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_no_bypass: got we=%b ready=%b expected 0 1", rf_we, lu_ready); end
      tick();
      lu_valid = 0;
      #2;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF)
         begin n_fail++; $display("FAIL drain_write: got we=%b a=%0d d=%h expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata); end
      n_checks++; if (fifo_count !== 2'd1) begin n_fail++; $display("FAIL drain_count1: got %0d expected 1", fifo_count); end
      tick(); #2;
      n_checks++; if (pending !== 32'h0 || fifo_count !== 2'd0 || rf_we !== 1'b0)
         begin n_fail++; $display("FAIL drain_after: got pend=%h cnt=%0d we=%b expected 0 0 0", pending, fifo_count, rf_we); end
   endtask

   task automatic test_pipeline_priority();
      reg_wrMW = 1; waddr_MW = 5'd3; wdata_MW = 32'h33;
      lu_valid = 1; lu_waddr = 5'd9; lu_wdata = 32'h99;
      tick();                                   // pipeline cycle 1 done, 9 pushed
      lu_waddr = 5'd10; lu_wdata = 32'hAA;
      #2;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33)
         begin n_fail++; $display("FAIL prio_pipe_wins: got we=%b a=%0d d=%h expected 1 3 33", rf_we, rf_waddr, rf_wdata); end
      tick();                                   // 10 pushed, count=2
      lu_valid = 0;
      #2;
      n_checks++; if (lu_ready !== 1'b0 || fifo_count !== 2'd2) begin n_fail++; $display("FAIL prio_full: got ready=%b cnt=%0d expected 0 2", lu_ready, fifo_count); end
      tick();                                   // fourth pipeline cycle
      #2;
      n_checks++; if (fifo_count !== 2'd2 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL prio_hold: got cnt=%0d a=%0d expected 2 3", fifo_count, rf_waddr); end
      tick();
      reg_wrMW = 0; waddr_MW = 0; wdata_MW = 0;
      #2;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99)
         begin n_fail++; $display("FAIL prio_older: got we=%b a=%0d d=%h expected 1 9 99", rf_we, rf_waddr, rf_wdata); end
      tick(); #2;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hAA || fifo_count !== 2'd1)
         begin n_fail++; $display("FAIL prio_younger: got we=%b a=%0d d=%h cnt=%0d expected 1 10 aa 1", rf_we, rf_waddr, rf_wdata, fifo_count); end
      tick(); #2;
      n_checks++; if (fifo_count !== 2'd0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL prio_empty: got cnt=%0d we=%b expected 0 0", fifo_count, rf_we); end
   endtask

   task automatic test_stall();
      tick();
      lu_issue = 1; lu_issue_rd = 5'd7;
      tick();
      lu_issue = 0; lu_issue_rd = 0; raddr2 = 5'd7;
      #2;
      n_checks++; if (stall_D !== 1'b1 || pending !== 32'h80) begin n_fail++; $display("FAIL stall_raddr2: got stall=%b pend=%h expected 1 00000080", stall_D, pending); end
      raddr2 = 0; id_rd = 5'd7; id_wr = 1;
      #2;
      n_checks++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL stall_id_rd: got %b expected 1", stall_D); end
      id_wr = 0;
      #2;
      n_checks++; if (stall_D !== 1'b0) begin n_fail++; $display("FAIL stall_id_wr0: got %b expected 0", stall_D); end
      id_rd = 0; lu_issue = 1; lu_issue_rd = 5'd7;
      #2;
      n_checks++; if (stall_D !== 1'b1) begin n_fail++; $display("FAIL stall_waw_issue: got %b expected 1", stall_D); end
      tick();
      lu_issue = 0; lu_issue_rd = 0; raddr2 = 5'd7;
      lu_valid = 1; lu_waddr = 5'd7; lu_wdata = 32'h77;
      tick();
      lu_valid = 0;
      #2;
      n_checks++; if (stall_D !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd7)
         begin n_fail++; $display("FAIL stall_drain_cycle: got stall=%b we=%b a=%0d expected 1 1 7", stall_D, rf_we, rf_waddr); end
      tick(); #2;
      n_checks++; if (stall_D !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL stall_released: got stall=%b pend=%h expected 0 0", stall_D, pending); end
      raddr2 = 0;
   endtask

   task automatic test_set_wins();
      // Result for r12 with no pending bit; issue r12 in its drain cycle.
      lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 32'h12;
      tick();
      lu_valid = 0; lu_issue = 1; lu_issue_rd = 5'd12;
      #2;
      n_checks++; if (rf_waddr !== 5'd12 || stall_D !== 1'b0) begin n_fail++; $display("FAIL setwins_pre: got a=%0d stall=%b expected 12 0", rf_waddr, stall_D); end
      tick();
      lu_issue = 0; lu_issue_rd = 0;
      #2;
      n_checks++; if (pending !== 32'h0000_1000) begin n_fail++; $display("FAIL setwins_pending: got %h expected 00001000", pending); end
      lu_valid = 1; lu_waddr = 5'd12; lu_wdata = 32'h12;
      tick();
      lu_valid = 0;
      tick(); #2;
      n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL setwins_cleanup: got %h expected 0", pending); end
   endtask

   task automatic test_zero_addr();
      lu_valid = 1; lu_waddr = 5'd0; lu_wdata = 32'h1234;
      #2;
      n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b expected 1", lu_ready); end
      tick();
      lu_valid = 0;
      #2;
      n_checks++; if (fifo_count !== 2'd0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_lu_drop: got cnt=%0d we=%b expected 0 0", fifo_count, rf_we); end
      reg_wrMW = 1; waddr_MW = 5'd0; wdata_MW = 32'h5;
      #2;
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_pipe: got we=%b expected 0", rf_we); end
      tick();
      reg_wrMW = 0; wdata_MW = 0;
   endtask

   task automatic test_full_push_pop();
      reg_wrMW = 1; waddr_MW = 5'd4; wdata_MW = 32'h44;
      lu_valid = 1; lu_waddr = 5'd1; lu_wdata = 32'h11;
      tick();
      lu_waddr = 5'd2; lu_wdata = 32'h22;
      tick();
      reg_wrMW = 0; waddr_MW = 0; wdata_MW = 0;
      lu_waddr = 5'd3; lu_wdata = 32'h3;
      #2;
      n_checks++; if (lu_ready !== 1'b0 || rf_waddr !== 5'd1 || fifo_count !== 2'd2)
         begin n_fail++; $display("FAIL full_pop_nopush: got ready=%b a=%0d cnt=%0d expected 0 1 2", lu_ready, rf_waddr, fifo_count); end
      tick(); #2;
      n_checks++; if (lu_ready !== 1'b1 || fifo_count !== 2'd1 || rf_waddr !== 5'd2)
         begin n_fail++; $display("FAIL full_retry: got ready=%b cnt=%0d a=%0d expected 1 1 2", lu_ready, fifo_count, rf_waddr); end
      tick();
      lu_valid = 0;
      #2;
      n_checks++; if (fifo_count !== 2'd1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3)
         begin n_fail++; $display("FAIL full_pushpop_order: got cnt=%0d a=%0d d=%h expected 1 3 3", fifo_count, rf_waddr, rf_wdata); end
      tick(); #2;
      n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL full_drained: got %0d expected 0", fifo_count); end
   endtask

   task automatic test_reset_midop();
      lu_issue = 1; lu_issue_rd = 5'd20;
      tick();
      lu_issue = 0; lu_issue_rd = 0;
      reg_wrMW = 1; waddr_MW = 5'd6; wdata_MW = 32'h66;
      lu_valid = 1; lu_waddr = 5'd20; lu_wdata = 32'h2020;
      tick();
      lu_waddr = 5'd21; lu_wdata = 32'h2121;
      tick();
      // Two entries queued; assert reset mid-cycle with a result still offered.
      reg_wrMW = 0; waddr_MW = 0; wdata_MW = 0;
      lu_waddr = 5'd22; lu_wdata = 32'h2222;
      rst = 1'b0;
      #1;
      n_checks++; if (fifo_count !== 2'd0 || pending !== 32'h0 || rf_we !== 1'b0 || lu_ready !== 1'b1)
         begin n_fail++; $display("FAIL midrst_async: got cnt=%0d pend=%h we=%b ready=%b expected 0 0 0 1", fifo_count, pending, rf_we, lu_ready); end
      tick(); tick(); #2;
      n_checks++; if (fifo_count !== 2'd0) begin n_fail++; $display("FAIL midrst_ignore_valid: got cnt=%0d expected 0", fifo_count); end
      lu_valid = 0;
      rst = 1'b1;
      tick(); #2;
      n_checks++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin n_fail++; $display("FAIL midrst_no_write1: got we=%b cnt=%0d expected 0 0", rf_we, fifo_count); end
      tick(); #2;
      n_checks++; if (rf_we !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL midrst_no_write2: got we=%b pend=%h expected 0 0", rf_we, pending); end
   endtask

   initial begin
      test_reset();
      test_basic_drain();
      test_pipeline_priority();
      test_stall();
      test_set_wins();
      test_zero_addr();
      test_full_push_pop();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
